// File: rtl/dmem_lsu_master.sv
// Load/store initiator between the MEM stage and the data memory bus.
// One access outstanding; handles lane steering, load extension, misalignment and timeouts.
module dmem_lsu_master #(
  parameter int TIMEOUT      = 64,
  parameter bit WRITE_POSTED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic [31:0] o_m_address,
  output logic        o_m_read,
  output logic        o_m_write,
  output logic [31:0] o_m_writedata,
  output logic [3:0]  o_m_byteenable,
  input  logic [31:0] i_m_readdata,
  input  logic        i_m_readdata_valid,
  input  logic        i_m_waitrequest
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             to_q, to_nxt;
  logic             capture;
  logic             accept;
  logic             mis;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       funct3_q;
  logic             we_q;
  logic [31:0]      rdata_q;

  // Codes other than byte/half widths behave as a word access.
  function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] a);
    case (f)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      default:        return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic we, input logic [2:0] f,
                                         input logic [1:0] a);
    if (!we) return 4'b1111;
    case (f[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f, input logic [31:0] d);
    case (f[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] s;
    s = d >> {a, 3'b000};
    case (f)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign mis    = is_misaligned(i_funct3, i_addr[1:0]);
  assign accept = (state == S_IDLE) && i_req_valid && !mis;

  always_comb begin
    state_nxt      = state;
    to_nxt         = to_q;
    capture        = 1'b0;
    o_m_read       = 1'b0;
    o_m_write      = 1'b0;
    o_m_address    = 32'h0;
    o_m_byteenable = 4'h0;
    o_m_writedata  = 32'h0;
    case (state)
      S_IDLE: begin
        to_nxt = 1'b0;
        if (accept) state_nxt = S_CMD;
      end
      S_CMD: begin
        o_m_address    = {addr_q[31:2], 2'b00};
        o_m_byteenable = byte_en(we_q, funct3_q, addr_q[1:0]);
        if (we_q) begin
          o_m_write     = 1'b1;
          o_m_writedata = lane_wdata(funct3_q, wdata_q);
          if (!i_m_waitrequest || WRITE_POSTED) state_nxt = S_DONE;
        end else begin
          o_m_read = 1'b1;
          if (!i_m_waitrequest) begin
            if (i_m_readdata_valid) begin
              capture   = 1'b1;
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_RESP;
            end
          end
        end
        if (state_nxt != S_DONE && cnt == CNT_LAST) begin
          state_nxt = S_DONE;
          to_nxt    = 1'b1;
        end
      end
      S_RESP: begin
        if (i_m_readdata_valid) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
          to_nxt    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Combinational request outputs are forced low while reset is held.
  assign o_misaligned = rst && i_req_valid && (state == S_IDLE) && mis;
  assign o_stall      = rst && (accept || state == S_CMD || state == S_RESP);
  assign o_done       = (state == S_DONE);
  assign o_timeout    = (state == S_DONE) && to_q;
  assign o_rdata      = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      to_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      to_q  <= to_nxt;
      if (accept) cnt <= '0;
      else if (state == S_CMD || state == S_RESP) cnt <= cnt + CNT_W'(1);
      if (capture) rdata_q <= load_ext(funct3_q, addr_q[1:0], i_m_readdata);
    end
  end

  // Request latch: only control state needs reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= i_addr;
      wdata_q  <= i_wdata;
      funct3_q <= i_funct3;
      we_q     <= i_req_we;
    end
  end

endmodule

// File: tb/tb_dmem_lsu_master.sv
// Directed bench for dmem_lsu_master with hand-computed expectations.
module tb_dmem_lsu_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, done, misaligned, timeout;
  logic [31:0] rdata;
  logic [31:0] m_address, m_writedata;
  logic        m_read, m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata = 32'h0;
  logic        m_readdata_valid = 1'b0;
  logic        m_waitrequest = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_lsu_master #(.TIMEOUT(8), .WRITE_POSTED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_funct3(funct3),
    .i_addr(addr), .i_wdata(wdata),
    .o_stall(stall), .o_done(done), .o_rdata(rdata),
    .o_misaligned(misaligned), .o_timeout(timeout),
    .o_m_address(m_address), .o_m_read(m_read), .o_m_write(m_write),
    .o_m_writedata(m_writedata), .o_m_byteenable(m_byteenable),
    .i_m_readdata(m_readdata), .i_m_readdata_valid(m_readdata_valid),
    .i_m_waitrequest(m_waitrequest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic we, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    funct3    = f;
    addr      = a;
    wdata     = d;
  endtask

  // Zero-wait load: data returned in the CMD cycle.
  task automatic load_zw(input logic [2:0] f, input logic [31:0] a, input logic [31:0] mem,
                         output logic [31:0] res);
    @(negedge clk);
    drive_req(1'b1, 1'b0, f, a, 32'h0);
    m_waitrequest = 1'b0; m_readdata_valid = 1'b0;
    #1 chk("ld_stall_idle", stall, 1'b1);
    @(negedge clk);
    m_readdata_valid = 1'b1; m_readdata = mem;
    #1 chk("ld_read", m_read, 1'b1);
    @(negedge clk);
    m_readdata_valid = 1'b0; req_valid = 1'b0;
    #1 chk("ld_done", done, 1'b1);
    res = rdata;
  endtask

  task automatic store_zw(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    @(negedge clk);
    drive_req(1'b1, 1'b1, f, a, d);
    m_waitrequest = 1'b0;
    @(negedge clk);
    #1;
    chk("st_write", m_write, 1'b1);
    chk("st_be", m_byteenable, exp_be);
    chk("st_wd", m_writedata, exp_wd);
    chk("st_addr", m_address, {a[31:2], 2'b00});
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("st_done", done, 1'b1);
  endtask

  initial begin
    logic [31:0] res;
    int stall_cnt, done_cnt, to_cnt, to_at;
    logic stable_ok;

    // Reset state
    #12;
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_cmds", {m_read, m_write, misaligned, timeout}, 4'b0000);
    chk("rst_addr", m_address, 32'h0);
    chk("rst_be_wd", {28'h0, m_byteenable} | m_writedata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Test 1: LW 0x10 zero-wait
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    #1;
    chk("t1_idle_stall", stall, 1'b1);
    chk("t1_idle_read", m_read, 1'b0);
    @(negedge clk);
    m_readdata_valid = 1'b1; m_readdata = 32'hDEADBEEF;
    #1;
    chk("t1_cmd_read", m_read, 1'b1);
    chk("t1_cmd_addr", m_address, 32'h10);
    chk("t1_cmd_stall", stall, 1'b1);
    @(negedge clk);
    m_readdata_valid = 1'b0; req_valid = 1'b0;
    #1;
    chk("t1_done", done, 1'b1);
    chk("t1_done_stall", stall, 1'b0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_done_read", m_read, 1'b0);
    @(negedge clk);
    #1;
    chk("t1_idle_done", done, 1'b0);
    chk("t1_rdata_hold", rdata, 32'hDEADBEEF);

    // Test 2: sub-word loads from 0x80FF0000
    load_zw(3'b000, 32'h13, 32'h80FF0000, res); chk("t2_lb", res, 32'hFFFFFF80);
    load_zw(3'b100, 32'h13, 32'h80FF0000, res); chk("t2_lbu", res, 32'h00000080);
    load_zw(3'b001, 32'h12, 32'h80FF0000, res); chk("t2_lh", res, 32'hFFFF80FF);
    load_zw(3'b101, 32'h12, 32'h80FF0000, res); chk("t2_lhu", res, 32'h000080FF);
    load_zw(3'b000, 32'h10, 32'h80FF0000, res); chk("t2_lb0", res, 32'h00000000);

    // Test 3: stores
    store_zw(3'b000, 32'h21, 32'h000000AB, 4'b0010, 32'hABABABAB);
    store_zw(3'b001, 32'h22, 32'h1234CDEF, 4'b1100, 32'hCDEFCDEF);
    store_zw(3'b010, 32'h24, 32'h1234CDEF, 4'b1111, 32'h1234CDEF);
    chk("t3_rdata_kept", rdata, 32'h00000000);

    // Posted store retires despite waitrequest
    @(negedge clk);
    drive_req(1'b1, 1'b1, 3'b010, 32'h30, 32'h55AA55AA);
    m_waitrequest = 1'b1;
    @(negedge clk);
    #1 chk("t3p_write", m_write, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; m_waitrequest = 1'b0;
    #1 chk("t3p_done", done, 1'b1);

    // Test 4: waitrequest 3 cycles then RESP
    stall_cnt = 0; done_cnt = 0; stable_ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      m_waitrequest = (k >= 1 && k <= 3);
      m_readdata_valid = (k == 5) || (k == 7);
      m_readdata = (k == 7) ? 32'h11111111 : 32'hCAFEF00D;
      req_valid = (k <= 5);
      if (k == 0) drive_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
      #1;
      stall_cnt += int'(stall);
      done_cnt  += int'(done);
      if (k >= 1 && k <= 4 && !(m_read && m_address == 32'h40 && m_byteenable == 4'hF))
        stable_ok = 1'b0;
      if (k == 5 && m_read) stable_ok = 1'b0;
    end
    chk("t4_stall_cnt", stall_cnt, 6);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_cmd_stable", stable_ok, 1'b1);
    chk("t4_rdata", rdata, 32'hCAFEF00D);
    m_readdata_valid = 1'b0;

    // Test 5: misaligned
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    #1;
    chk("t5_lw_mis", misaligned, 1'b1);
    chk("t5_lw_stall", stall, 1'b0);
    @(negedge clk);
    drive_req(1'b1, 1'b1, 3'b001, 32'h3, 32'h0);
    #1;
    chk("t5_lw_nobus", {m_read, m_write}, 2'b00);
    chk("t5_sh_mis", misaligned, 1'b1);
    chk("t5_sh_stall", stall, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("t5_sh_nobus", {m_read, m_write, done}, 3'b000);
    chk("t5_mis_clear", misaligned, 1'b0);

    // Test 6: timeout with waitrequest stuck
    to_cnt = 0; to_at = -1; done_cnt = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0) drive_req(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
      if (k == 9) req_valid = 1'b0;
      m_waitrequest = 1'b1;
      #1;
      if (timeout) begin
        to_cnt++;
        if (to_at < 0) to_at = k;
      end
      done_cnt += int'(done);
      if (k == 9) chk("t6_to_read_drop", m_read, 1'b0);
    end
    chk("t6_to_cycle", to_at, 9);
    chk("t6_to_cnt", to_cnt, 1);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_rdata_kept", rdata, 32'hCAFEF00D);

    // Asynchronous reset mid-CMD
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h90, 32'h0);
    @(negedge clk);
    #1 chk("t6_cmd_read", m_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_read", m_read, 1'b0);
    chk("t6_rst_stall", stall, 1'b0);
    chk("t6_rst_rdata", rdata, 32'h0);
    chk("t6_rst_addr", m_address, 32'h0);
    @(negedge clk);
    req_valid = 1'b0; m_waitrequest = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1 chk("t6_post_idle", {stall, done, m_read}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
